ifetch_line_server: RTL and testbench

IFETCH_LINE_SERVER -- requirements
Module: ifetch_line_server

---
 rtl/ifetch_line_server_pkg.sv | 15 +
 rtl/ifetch_line_server.sv | 131 +++++++++++++
 tb/tb_ifetch_line_server.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_line_server_pkg.sv
// Shared line/beat geometry and FSM state type for the instruction-fetch line server.
package CACHE;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned BEAT_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        BUS_REQ,
        COLLECT,
        RESP
    } ifl_state_t;

endpackage

// File: rtl/ifetch_line_server.sv
// Instruction-fetch line server: a one-line buffer in front of a burst read bus.
// Hits answer one cycle after acceptance; misses fetch the whole line beat by beat.
// A withdrawn or flushed fetch still completes its burst so the buffer ends up filled.
module ifetch_line_server #(
    parameter int unsigned LINE_BYTES = CACHE::LINE_BYTES,
    parameter int unsigned BEAT_BYTES = CACHE::BEAT_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [63:0]             req_addr,
    input  logic                    flush,
    output logic                    resp_valid,
    output logic [0:LINE_BYTES*8-1] resp_line,
    output logic                    bus_req_valid,
    output logic [63:0]             bus_req_addr,
    input  logic                    bus_req_ack,
    input  logic                    bus_resp_valid,
    input  logic [BEAT_BYTES*8-1:0] bus_resp_data,
    output logic                    bus_resp_ack
);
    import CACHE::*;

    localparam int unsigned LINE_BITS = LINE_BYTES * 8;
    localparam int unsigned BEAT_BITS = BEAT_BYTES * 8;
    localparam int unsigned BEATS     = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned OFF_BITS  = $clog2(LINE_BYTES);
    localparam int unsigned CNT_BITS  = $clog2(BEATS);
    localparam int unsigned TAG_BITS  = 64 - OFF_BITS;

    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

    ifl_state_t            state;
    logic                  buf_valid;
    logic [TAG_BITS-1:0]   buf_tag;
    logic [0:LINE_BITS-1]  buf_data;
    logic [TAG_BITS-1:0]   req_tag;
    logic [CNT_BITS-1:0]   beat_cnt;
    logic                  cancelled;
    logic                  bus_req_q;
    logic                  resp_q;

    logic                  hit;
    logic                  abort;
    logic                  beat_fire;
    logic                  unused_offset_bits;

    assign hit                = buf_valid && (buf_tag == req_addr[63:OFF_BITS]);
    assign abort              = flush || !req_valid;
    assign beat_fire          = (state == COLLECT) && bus_resp_valid;
    assign unused_offset_bits = ^req_addr[OFF_BITS-1:0];

    // Output stage: registered flags, with flush able to kill a response in its own cycle
    // and reset forcing every output quiet.
    always_comb begin
        resp_valid    = resp_q && !flush && !reset;
        bus_req_valid = bus_req_q && !reset;
        bus_req_addr  = reset ? '0 : {req_tag, {OFF_BITS{1'b0}}};
        bus_resp_ack  = beat_fire && !reset;
        resp_line     = reset ? '0 : buf_data;
    end

    // Request sequencing, line buffer fill and response/cancel tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            req_tag   <= '0;
            beat_cnt  <= '0;
            cancelled <= 1'b0;
            bus_req_q <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        req_tag   <= req_addr[63:OFF_BITS];
                        cancelled <= 1'b0;
                        if (hit) begin
                            state  <= HIT;
                            resp_q <= 1'b1;
                        end else begin
                            state     <= BUS_REQ;
                            bus_req_q <= 1'b1;
                        end
                    end
                end
                HIT: begin
                    state <= IDLE;
                end
                BUS_REQ: begin
                    if (abort) cancelled <= 1'b1;
                    if (bus_req_ack) begin
                        bus_req_q <= 1'b0;
                        beat_cnt  <= '0;
                        buf_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (abort) cancelled <= 1'b1;
                    if (bus_resp_valid) begin
                        buf_data[BEAT_BITS * beat_cnt +: BEAT_BITS] <= bus_resp_data;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            buf_valid <= 1'b1;
                            buf_tag   <= req_tag;
                            // A cancel arriving with the final beat must also suppress the response.
                            if (!cancelled && !abort) begin
                                state  <= RESP;
                                resp_q <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_line_server.sv
// Self-checking bench for ifetch_line_server: a transaction-level driver predicts every
// cycle's outputs from a simple line-buffer model; one negedge process compares them.
module tb_ifetch_line_server;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic [63:0]  req_addr = '0;
    logic         flush = 1'b0;
    logic         resp_valid;
    logic [0:511] resp_line;
    logic         bus_req_valid;
    logic [63:0]  bus_req_addr;
    logic         bus_req_ack = 1'b0;
    logic         bus_resp_valid = 1'b0;
    logic [63:0]  bus_resp_data = '0;
    logic         bus_resp_ack;

    ifetch_line_server #(
        .LINE_BYTES(64),
        .BEAT_BYTES(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_line     (resp_line),
        .bus_req_valid (bus_req_valid),
        .bus_req_addr  (bus_req_addr),
        .bus_req_ack   (bus_req_ack),
        .bus_resp_valid(bus_resp_valid),
        .bus_resp_data (bus_resp_data),
        .bus_resp_ack  (bus_resp_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations set by the driver.
    bit          chk_en = 1'b0;
    bit          exp_resp_valid = 1'b0;
    bit          exp_bus_req_valid = 1'b0;
    logic [63:0] exp_bus_req_addr = '0;
    bit          exp_bus_resp_ack = 1'b0;
    bit          exp_reset_chk = 1'b0;

    // Line-buffer model.
    bit          mvalid = 1'b0;
    logic [57:0] mtag = '0;
    logic [63:0] mdata [8];

    // Observations used by the literal checks.
    int           resp_cnt = 0;
    int           breq_cnt = 0;
    int           breq_hi = 0;
    bit           prev_brv = 1'b0;
    logic [0:511] last_line = '0;
    logic [63:0]  last_baddr = '0;

    task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare DUT outputs against the driver's expectations every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check1("resp_valid", 64'(resp_valid), 64'(exp_resp_valid));
            check1("bus_req_valid", 64'(bus_req_valid), 64'(exp_bus_req_valid));
            check1("bus_resp_ack", 64'(bus_resp_ack), 64'(exp_bus_resp_ack));
            if (exp_bus_req_valid)
                check1("bus_req_addr", bus_req_addr, exp_bus_req_addr);
            if (exp_resp_valid)
                for (int k = 0; k < 8; k++)
                    check1($sformatf("resp_line_beat%0d", k), resp_line[k*64 +: 64], mdata[k]);
            if (exp_reset_chk) begin
                check1("reset_bus_req_addr", bus_req_addr, 64'h0);
                check1("reset_resp_line_nonzero", 64'(|resp_line), 64'h0);
            end
            if (resp_valid) begin
                resp_cnt++;
                last_line = resp_line;
            end
            if (bus_req_valid && !prev_brv) breq_cnt++;
            if (bus_req_valid) begin
                breq_hi++;
                last_baddr = bus_req_addr;
            end
            prev_brv = bus_req_valid;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        exp_resp_valid    = 1'b0;
        exp_bus_req_valid = 1'b0;
        exp_bus_req_addr  = '0;
        exp_bus_resp_ack  = 1'b0;
        exp_reset_chk     = 1'b0;
        bus_req_ack       = 1'b0;
        bus_resp_valid    = 1'b0;
        flush             = 1'b0;
    endtask

    // One fetch transaction; beat indices of -1 disable that event.
    task automatic run_req(input logic [63:0] addr, input int ack_dly, input int gap,
                           input int flush_beat, input int drop_beat, input int reset_beat,
                           input bit flush_resp, input bit idx_data);
        logic [57:0] tg;
        logic [63:0] d;
        bit          is_hit;
        bit          canc;
        tg     = addr[63:6];
        is_hit = mvalid && (mtag == tg);
        canc   = 1'b0;

        next_cycle();
        req_valid = 1'b1;
        req_addr  = addr;

        if (is_hit) begin
            next_cycle();
            if (flush_resp) flush = 1'b1;
            else exp_resp_valid = 1'b1;
            next_cycle();
            req_valid = 1'b0;
            return;
        end

        for (int i = 0; i <= ack_dly; i++) begin
            next_cycle();
            req_addr          = {$urandom(), $urandom()};
            exp_bus_req_valid = 1'b1;
            exp_bus_req_addr  = {tg, 6'b0};
            if (i == ack_dly) bus_req_ack = 1'b1;
        end
        mvalid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) next_cycle();
            next_cycle();
            if (k == reset_beat) begin
                reset         = 1'b1;
                exp_reset_chk = 1'b1;
                mvalid        = 1'b0;
                for (int j = 0; j < 8; j++) mdata[j] = '0;
                next_cycle();
                reset     = 1'b0;
                req_valid = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    next_cycle();
                    bus_resp_valid = 1'b1;
                    bus_resp_data  = {$urandom(), $urandom()};
                end
                next_cycle();
                return;
            end
            d = idx_data ? 64'(k) : {$urandom(), $urandom()};
            bus_resp_valid   = 1'b1;
            bus_resp_data    = d;
            exp_bus_resp_ack = 1'b1;
            mdata[k]         = d;
            if (k == flush_beat) begin
                flush     = 1'b1;
                req_valid = 1'b0;
                canc      = 1'b1;
            end
            if (k == drop_beat) begin
                req_valid = 1'b0;
                canc      = 1'b1;
            end
        end
        mvalid = 1'b1;
        mtag   = tg;

        next_cycle();
        if (!canc) begin
            if (flush_resp) flush = 1'b1;
            else exp_resp_valid = 1'b1;
        end
        next_cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int r0, b0, h0;
        for (int j = 0; j < 8; j++) mdata[j] = '0;

        next_cycle();
        chk_en        = 1'b1;
        exp_reset_chk = 1'b1;
        next_cycle();
        exp_reset_chk = 1'b1;
        next_cycle();
        reset = 1'b0;

        // Miss with indexed beat data.
        r0 = resp_cnt; b0 = breq_cnt;
        run_req(64'h1048, 0, 0, -1, -1, -1, 1'b0, 1'b1);
        check1("miss_resp_count", 64'(resp_cnt - r0), 64'd1);
        check1("miss_bus_req_count", 64'(breq_cnt - b0), 64'd1);
        check1("miss_bus_addr", last_baddr, 64'h1040);
        check1("miss_line_beat0", last_line[0:63], 64'h0);
        check1("miss_line_beat7", last_line[448:511], 64'h7);

        // Hit on same line.
        r0 = resp_cnt; b0 = breq_cnt;
        run_req(64'h1070, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        check1("hit_resp_count", 64'(resp_cnt - r0), 64'd1);
        check1("hit_no_bus_req", 64'(breq_cnt - b0), 64'd0);
        check1("hit_line_beat7", last_line[448:511], 64'h7);

        // Delayed bus acceptance.
        b0 = breq_cnt; h0 = breq_hi;
        run_req(64'h2008, 5, 0, -1, -1, -1, 1'b0, 1'b0);
        check1("backpressure_single_req", 64'(breq_cnt - b0), 64'd1);
        check1("backpressure_hold_cycles", 64'(breq_hi - h0), 64'd6);
        check1("backpressure_addr", last_baddr, 64'h2000);

        // Flush mid-burst, then the filled line hits.
        r0 = resp_cnt;
        run_req(64'h1040, 0, 0, 3, -1, -1, 1'b0, 1'b0);
        check1("flush_no_resp", 64'(resp_cnt - r0), 64'd0);
        r0 = resp_cnt; b0 = breq_cnt;
        run_req(64'h1040, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        check1("after_flush_hit_resp", 64'(resp_cnt - r0), 64'd1);
        check1("after_flush_no_bus_req", 64'(breq_cnt - b0), 64'd0);

        // Reset mid-burst, then the same line misses again.
        run_req(64'h3000, 0, 0, -1, -1, 4, 1'b0, 1'b0);
        r0 = resp_cnt; b0 = breq_cnt;
        run_req(64'h1040, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        check1("after_reset_miss_req", 64'(breq_cnt - b0), 64'd1);
        check1("after_reset_resp", 64'(resp_cnt - r0), 64'd1);

        // Gapped beats.
        r0 = resp_cnt;
        run_req(64'h4010, 1, 2, -1, -1, -1, 1'b0, 1'b0);
        check1("gapped_resp_count", 64'(resp_cnt - r0), 64'd1);

        // Flush coincident with the final beat: filled, no response, then hit.
        r0 = resp_cnt;
        run_req(64'h5000, 0, 0, 7, -1, -1, 1'b0, 1'b0);
        check1("final_beat_flush_no_resp", 64'(resp_cnt - r0), 64'd0);
        b0 = breq_cnt;
        run_req(64'h5020, 0, 0, -1, -1, -1, 1'b0, 1'b0);
        check1("final_beat_flush_then_hit", 64'(breq_cnt - b0), 64'd0);

        // Randomized traffic over a few lines so hits and misses mix.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            int fb, db, rb;
            a  = ({58'($urandom_range(2)) + 58'h40, 6'b0}) | 64'($urandom_range(63));
            fb = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
            db = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
            rb = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : -1;
            run_req(a, int'($urandom_range(4)), int'($urandom_range(2)), fb, db, rb,
                    bit'($urandom_range(5) == 0), 1'b0);
        end

        next_cycle();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
